counter_mode: RTL and testbench

Parametrised up/down counter with a programmable terminal value and three run modes: wrap, saturate and one-shot. It is the general-purpose successor to the plain load/enable counter. It adds direction control, a terminal-count pulse, a sticky overflow flag and a one-shot done flag. It sits in timer, prescaler and sequencing logic as a drop-in counting primitive; all outputs are registered.

---
 rtl/counter_pkg.sv | 8 +
 rtl/counter_mode.sv | 89 ++++++++
 tb/tb_counter_mode.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared run-mode encodings for the counter_mode primitive.
package counter_pkg;
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;
endpackage

// File: rtl/counter_mode.sv
// counter_mode: up/down counter with programmable terminal value and wrap/saturate/one-shot modes.
module counter_mode
    import counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             ovf,
    output logic             done
);
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
        $error("counter_mode: MAX_VAL out of range 1..2**WIDTH-1");
    end

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             tc;
        logic             ovf_set;
        logic             done_set;
    } step_t;

    // One enabled step; the extra MSB keeps the down-step below zero from aliasing.
    function automatic step_t cnt_step(input logic [WIDTH-1:0] cnt, input logic up, input logic [1:0] md);
        logic [WIDTH:0] cur, bnd, nxt;
        logic at_b;
        step_t s;
        cur = {1'b0, cnt};
        bnd = up ? MAX_W : '0;
        at_b = cur == bnd;
        nxt = up ? cur + 1'b1 : cur - 1'b1;
        s.cnt = nxt[WIDTH-1:0];
        s.tc = at_b;
        s.ovf_set = at_b;
        s.done_set = 1'b0;
        if (md == MODE_ONESHOT) begin
            s.cnt = at_b ? cnt : nxt[WIDTH-1:0];
            s.tc = at_b || nxt == bnd;
            s.ovf_set = 1'b0;
            s.done_set = s.tc;
        end else if (md == MODE_SAT) begin
            s.cnt = at_b ? cnt : nxt[WIDTH-1:0];
        end else if (at_b) begin
            s.cnt = up ? '0 : MAX_W[WIDTH-1:0];
        end
        return s;
    endfunction

    step_t st;
    logic [WIDTH-1:0] ld_val;

    always_comb begin
        st = cnt_step(cnt_out, up_dn, mode);
        ld_val = {1'b0, cnt_in} > MAX_W ? MAX_W[WIDTH-1:0] : cnt_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_out <= '0;
            tc <= 1'b0;
            ovf <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            cnt_out <= ld_val;
            tc <= 1'b0;
            ovf <= ovf & ~clr_ovf;
            done <= 1'b0;
        end else if (enab && !done) begin
            cnt_out <= st.cnt;
            tc <= st.tc;
            ovf <= st.ovf_set | (ovf & ~clr_ovf);
            done <= st.done_set;
        end else begin
            tc <= 1'b0;
            ovf <= ovf & ~clr_ovf;
        end
    end
endmodule

// File: tb/tb_counter_mode.sv
// tb_counter_mode: directed stimulus against a behavioural model plus full-range wrap sweeps.
module tb_counter_mode;
    localparam int MX = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, load = 1'b0, enab = 1'b0, up_dn = 1'b1, clr_ovf = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] cnt_in = 4'd0;
    logic [3:0] cnt_out;
    logic tc, ovf, done;

    counter_mode #(.WIDTH(4), .MAX_VAL(MX)) dut (
        .clk(clk), .rst(rst), .load(load), .enab(enab), .up_dn(up_dn), .mode(mode),
        .clr_ovf(clr_ovf), .cnt_in(cnt_in), .cnt_out(cnt_out), .tc(tc), .ovf(ovf), .done(done)
    );

    logic rst_sw = 1'b1;
    logic [0:0] c1;
    logic [7:0] c8;
    logic tc1, ovf1, done1, tc8, ovf8, done8;

    counter_mode #(.WIDTH(1), .MAX_VAL(1)) dut_w1 (
        .clk(clk), .rst(rst_sw), .load(1'b0), .enab(1'b1), .up_dn(1'b1), .mode(2'b00),
        .clr_ovf(1'b0), .cnt_in(1'b0), .cnt_out(c1), .tc(tc1), .ovf(ovf1), .done(done1)
    );

    counter_mode #(.WIDTH(8), .MAX_VAL(255)) dut_w8 (
        .clk(clk), .rst(rst_sw), .load(1'b0), .enab(1'b1), .up_dn(1'b1), .mode(2'b00),
        .clr_ovf(1'b0), .cnt_in(8'd0), .cnt_out(c8), .tc(tc8), .ovf(ovf8), .done(done8)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ranges and modular arithmetic straight from the counting rules.
    int m_cnt, m_tc, m_ovf, m_done;
    bit m_valid = 0;
    always @(posedge clk) begin
        int b, nxt, set;
        set = 0;
        if (rst) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_done = 0; m_valid = 1;
        end else if (load) begin
            m_cnt = (cnt_in > MX) ? MX : int'(cnt_in);
            m_tc = 0; m_done = 0;
            m_ovf = m_ovf && !clr_ovf;
        end else if (enab && !m_done) begin
            b = up_dn ? MX : 0;
            if (mode == 2'b10) begin
                nxt = up_dn ? (m_cnt < MX ? m_cnt + 1 : MX) : (m_cnt > 0 ? m_cnt - 1 : 0);
                m_tc = (nxt == b) ? 1 : 0;
                m_done = m_tc;
                m_cnt = nxt;
            end else if (mode == 2'b01) begin
                set = (m_cnt == b) ? 1 : 0;
                m_cnt = up_dn ? (m_cnt < MX ? m_cnt + 1 : MX) : (m_cnt > 0 ? m_cnt - 1 : 0);
                m_tc = set;
            end else begin
                set = (m_cnt == b) ? 1 : 0;
                m_cnt = (m_cnt + (up_dn ? 1 : MX)) % (MX + 1);
                m_tc = set;
            end
            m_ovf = (set != 0 || (m_ovf != 0 && !clr_ovf)) ? 1 : 0;
        end else begin
            m_tc = 0;
            m_ovf = m_ovf && !clr_ovf;
        end
    end

    int k1 = 0, k8 = 0;
    always @(posedge clk) begin
        k1 = rst_sw ? 0 : k1 + 1;
        k8 = rst_sw ? 0 : k8 + 1;
    end

    bit sw_valid = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_cnt", int'(cnt_out), m_cnt);
            chk("m_tc", int'(tc), m_tc);
            chk("m_ovf", int'(ovf), m_ovf);
            chk("m_done", int'(done), m_done);
        end
        if (sw_valid) begin
            chk("w1_cnt", int'(c1), k1 % 2);
            chk("w1_tc", int'(tc1), (k1 > 0 && k1 % 2 == 0) ? 1 : 0);
            chk("w8_cnt", int'(c8), k8 % 256);
            chk("w8_tc", int'(tc8), (k8 > 0 && k8 % 256 == 0) ? 1 : 0);
        end
    end

    task automatic drive(input logic r, input logic ld, input logic en, input logic up,
                         input logic [1:0] md, input logic clr, input logic [3:0] din);
        rst = r; load = ld; enab = en; up_dn = up; mode = md; clr_ovf = clr; cnt_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst_sw = 1'b1;
        drive(1, 1, 1, 1, 2'b00, 0, 4'd7);
        rst_sw = 1'b0;
        sw_valid = 1;
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_flags", {tc, ovf, done}, 0);
        // wrap up: 1..9,0,1,2
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 1, 2'b00, 0, 4'd0);
            chk("wrap_up_cnt", int'(cnt_out), (i + 1) % 10);
            chk("wrap_up_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        chk("wrap_up_ovf", int'(ovf), 1);
        // load clamp then wrap down
        drive(0, 1, 0, 0, 2'b00, 0, 4'd15);
        chk("load_clamp", int'(cnt_out), 9);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 0, 2'b00, 0, 4'd0);
            chk("wrap_dn_cnt", int'(cnt_out), (i == 9) ? 9 : 8 - i);
            chk("wrap_dn_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 2'b00, 1, 4'd0);
        chk("clr_ovf", int'(ovf), 0);
        // saturate
        drive(0, 1, 0, 1, 2'b01, 0, 4'd8);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 2'b01, 0, 4'd0);
            chk("sat_up_cnt", int'(cnt_out), 9);
            chk("sat_up_tc", int'(tc), (i > 0) ? 1 : 0);
        end
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 2'b01, 0, 4'd0);
        chk("sat_floor", int'(cnt_out), 0);
        chk("sat_floor_tc", int'(tc), 1);
        // one-shot
        drive(0, 0, 0, 1, 2'b00, 1, 4'd0);
        drive(0, 1, 0, 1, 2'b10, 0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 2'b10, 0, 4'd0);
            chk("os_cnt", int'(cnt_out), 7 + i);
            chk("os_done", int'(done), (i == 2) ? 1 : 0);
            chk("os_tc", int'(tc), (i == 2) ? 1 : 0);
        end
        chk("os_no_ovf", int'(ovf), 0);
        drive(0, 0, 1, 1, 2'b10, 0, 4'd0);
        chk("os_hold", {cnt_out, tc, done}, {4'd9, 1'b0, 1'b1});
        drive(0, 0, 1, 1, 2'b00, 0, 4'd0);
        chk("os_done_mode_chg", {cnt_out, done}, {4'd9, 1'b1});
        drive(0, 1, 0, 1, 2'b10, 0, 4'd2);
        chk("os_reload", {cnt_out, done}, {4'd2, 1'b0});
        drive(0, 1, 0, 1, 2'b10, 0, 4'd9);
        drive(0, 0, 1, 1, 2'b10, 0, 4'd0);
        chk("os_at_b", {cnt_out, tc, done}, {4'd9, 1'b1, 1'b1});
        // priority and simultaneity
        drive(0, 1, 1, 1, 2'b00, 0, 4'd5);
        chk("load_over_enab", int'(cnt_out), 5);
        drive(1, 1, 1, 1, 2'b00, 0, 4'd5);
        chk("rst_over_load", int'(cnt_out), 0);
        drive(0, 1, 0, 1, 2'b11, 0, 4'd9);
        drive(0, 0, 1, 1, 2'b11, 1, 4'd0);
        chk("set_beats_clr", {cnt_out, tc, ovf}, {4'd0, 1'b1, 1'b1});
        drive(0, 0, 1, 1, 2'b11, 0, 4'd0);
        chk("mode11_wrap", {cnt_out, ovf}, {4'd1, 1'b1});
        chk("model_pin", m_cnt, 1);
        // let the full-range sweeps run past two periods of the 8-bit counter
        cyc = 0;
        while (k8 < 600 && cyc < 2000) begin
            drive(0, 0, 1, 1, 2'b00, 0, 4'd0);
            cyc++;
        end
        chk("sweep_budget", (k8 >= 600) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
